// File: rtl/zzcpu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zzcpu_core_pkg
// Description : Shared opcodes, function codes, ALU ops and pipeline record
//               for the zzcpu core.
// Revision    : 1.0 - initial release
// ============================================================================
package zzcpu_core_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_LI    = 5'b01101;
    localparam logic [4:0] OP_ADDIU = 5'b01001;
    localparam logic [4:0] OP_RRR   = 5'b11100;
    localparam logic [4:0] OP_LOGIC = 5'b11101;
    localparam logic [4:0] OP_SHIFT = 5'b00110;
    localparam logic [4:0] OP_LW    = 5'b10011;
    localparam logic [4:0] OP_SW    = 5'b11011;

    localparam logic [1:0] c_FN_ADDU = 2'b01;
    localparam logic [1:0] c_FN_SUBU = 2'b11;
    localparam logic [1:0] c_FN_SLL  = 2'b00;
    localparam logic [1:0] c_FN_SRA  = 2'b11;
    localparam logic [4:0] c_FN_AND  = 5'b01100;
    localparam logic [4:0] c_FN_OR   = 5'b01101;

    localparam logic [15:0] c_NOP_WORD = 16'h0800;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_SLL    = 3'd5,
        ALU_SRA    = 3'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LW   = 2'd2,
        CLS_SW   = 2'd3
    } op_class_e;

    typedef struct packed {
        op_class_e   cls;
        logic [2:0]  rd;
        logic [15:0] result;
        logic [15:0] sdata;
    } exmem_t;

    localparam exmem_t c_BUBBLE = '{cls: CLS_NONE, rd: 3'd0, result: 16'h0000, sdata: 16'h0000};

    function automatic logic [15:0] alu_eval(input alu_op_e op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] y;
        y = b;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLL: y = a << b[3:0];
            ALU_SRA: y = $signed(a) >>> b[3:0];
            default: y = b;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zzcpu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : zzcpu_core_if
// Description : Instruction input, write-back display and Ram1 control bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface zzcpu_core_if;
    logic [15:0] l;
    logic [15:0] light;
    logic [17:0] Ram1Addr;
    logic        Ram1OE;
    logic        Ram1WE;
    logic        Ram1EN;

    modport master (
        input  l,
        output light,
        output Ram1Addr,
        output Ram1OE,
        output Ram1WE,
        output Ram1EN
    );

    modport slave (
        output l,
        input  light,
        input  Ram1Addr,
        input  Ram1OE,
        input  Ram1WE,
        input  Ram1EN
    );
endinterface
`default_nettype wire

// File: rtl/zzcpu_core_regfile.sv
`default_nettype none
// ============================================================================
// Module      : zzcpu_regfile
// Description : 8x16 register file, two async reads, one sync write with
//               write-before-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module zzcpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_ra_addr,
    output logic [15:0] o_ra_data,
    input  logic [2:0]  i_rb_addr,
    output logic [15:0] o_rb_data,
    input  logic        i_we,
    input  logic [2:0]  i_wa,
    input  logic [15:0] i_wd
);

    logic [15:0] r_regs [0:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_ra_data = (i_we && (i_wa == i_ra_addr)) ? i_wd : r_regs[i_ra_addr];
    assign o_rb_data = (i_we && (i_wa == i_rb_addr)) ? i_wd : r_regs[i_rb_addr];

endmodule
`default_nettype wire

// File: rtl/zzcpu_core.sv
`default_nettype none
// ============================================================================
// Module      : zzcpu_core
// Description : 3-stage (IF/ID, EX, MEM/WB) THCO-MIPS subset core; the
//               instruction comes straight from the switch input each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module zzcpu_core
    import zzcpu_core_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    zzcpu_core_if.master bus,
    inout  wire [15:0]   Ram1Data,
    output logic [17:0]  Ram2Addr,
    inout  wire [15:0]   Ram2Data,
    output logic         Ram2OE,
    output logic         Ram2WE,
    output logic         Ram2EN,
    input  logic         data_ready,
    input  logic         tbre,
    input  logic         tsre,
    output logic         wrn,
    output logic         rdn
);

    logic [15:0] r_ir;
    exmem_t      r_ex;
    logic [15:0] r_light;

    exmem_t      w_ex_next;
    alu_op_e     w_alu_op;
    logic [4:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [2:0]  w_rz;
    logic [3:0]  w_shamt;
    logic [15:0] w_rx_data;
    logic [15:0] w_ry_data;
    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic        w_wb_en;
    logic [15:0] w_wb_data;
    logic        w_mem_en;
    logic        w_unused_uart;

    assign w_op    = r_ir[15:11];
    assign w_rx    = r_ir[10:8];
    assign w_ry    = r_ir[7:5];
    assign w_rz    = r_ir[4:2];
    // A zero shift field encodes a shift of eight.
    assign w_shamt = (r_ir[4:2] == 3'd0) ? 4'd8 : {1'b0, r_ir[4:2]};

    zzcpu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (w_rx),
        .o_ra_data (w_rx_data),
        .i_rb_addr (w_ry),
        .o_rb_data (w_ry_data),
        .i_we      (w_wb_en),
        .i_wa      (r_ex.rd),
        .i_wd      (w_wb_data)
    );

    always_comb begin
        w_ex_next = c_BUBBLE;
        w_alu_op  = ALU_PASS_B;
        w_op_a    = w_rx_data;
        w_op_b    = 16'h0000;
        w_ex_next.rd = w_rx;
        case (w_op)
            OP_LI: begin
                w_ex_next.cls = CLS_ALU;
                w_op_b        = {8'h00, r_ir[7:0]};
            end
            OP_ADDIU: begin
                w_ex_next.cls = CLS_ALU;
                w_alu_op      = ALU_ADD;
                w_op_b        = {{8{r_ir[7]}}, r_ir[7:0]};
            end
            OP_RRR: begin
                w_ex_next.rd = w_rz;
                w_op_b       = w_ry_data;
                if (r_ir[1:0] == c_FN_ADDU) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_ADD;
                end else if (r_ir[1:0] == c_FN_SUBU) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_SUB;
                end
            end
            OP_LOGIC: begin
                w_op_b = w_ry_data;
                if (r_ir[4:0] == c_FN_AND) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_AND;
                end else if (r_ir[4:0] == c_FN_OR) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_OR;
                end
            end
            OP_SHIFT: begin
                w_op_a = w_ry_data;
                w_op_b = {12'h000, w_shamt};
                if (r_ir[1:0] == c_FN_SLL) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_SLL;
                end else if (r_ir[1:0] == c_FN_SRA) begin
                    w_ex_next.cls = CLS_ALU;
                    w_alu_op      = ALU_SRA;
                end
            end
            OP_LW: begin
                w_ex_next.cls = CLS_LW;
                w_ex_next.rd  = w_ry;
                w_alu_op      = ALU_ADD;
                w_op_b        = {{11{r_ir[4]}}, r_ir[4:0]};
            end
            OP_SW: begin
                w_ex_next.cls   = CLS_SW;
                w_ex_next.sdata = w_ry_data;
                w_alu_op        = ALU_ADD;
                w_op_b          = {{11{r_ir[4]}}, r_ir[4:0]};
            end
            default: begin
                w_ex_next.cls = CLS_NONE;
            end
        endcase
        w_ex_next.result = alu_eval(w_alu_op, w_op_a, w_op_b);
    end

    assign w_wb_en   = (r_ex.cls == CLS_ALU) || (r_ex.cls == CLS_LW);
    assign w_wb_data = (r_ex.cls == CLS_LW) ? Ram1Data : r_ex.result;
    assign w_mem_en  = (r_ex.cls == CLS_LW) || (r_ex.cls == CLS_SW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= c_NOP_WORD;
            r_ex    <= c_BUBBLE;
            r_light <= 16'h0000;
        end else begin
            r_ir <= bus.l;
            r_ex <= w_ex_next;
            if (w_wb_en) begin
                r_light <= w_wb_data;
            end
        end
    end

    // WE strobes only in the clk-low half so address/data are stable around both WE edges.
    assign bus.Ram1EN   = ~w_mem_en;
    assign bus.Ram1OE   = ~(r_ex.cls == CLS_LW);
    assign bus.Ram1WE   = ~((r_ex.cls == CLS_SW) & ~clk);
    assign bus.Ram1Addr = w_mem_en ? {2'b00, r_ex.result} : 18'h00000;
    assign Ram1Data     = (r_ex.cls == CLS_SW) ? r_ex.sdata : 16'hzzzz;
    assign bus.light    = r_light;

    assign Ram2Addr = 18'h00000;
    assign Ram2Data = 16'hzzzz;
    assign Ram2OE   = 1'b1;
    assign Ram2WE   = 1'b1;
    assign Ram2EN   = 1'b1;
    assign wrn      = 1'b1;
    assign rdn      = 1'b1;

    assign w_unused_uart = ^{data_ready, tbre, tsre};

endmodule
`default_nettype wire

// File: tb/tb_zzcpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_zzcpu_core
// Description : Directed plus random instruction stream against an ISA-level
//               model with an SRAM model on Ram1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zzcpu_core;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        int          kind;   // 0 none, 1 load, 2 store
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] light;
    } hist_t;

    logic        clk;
    logic        rst;
    wire  [15:0] Ram1Data;
    wire  [15:0] Ram2Data;
    logic [17:0] Ram2Addr;
    logic        Ram2OE, Ram2WE, Ram2EN;
    logic        wrn, rdn;
    logic        probe_en;
    logic [15:0] probe_val;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sram [0:65535];
    logic [15:0] m_regs [0:7];
    logic [15:0] m_mem [logic [15:0]];
    logic [15:0] m_light;
    hist_t       hist [$];

    zzcpu_core_if bus ();

    zzcpu_core dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .Ram1Data   (Ram1Data),
        .Ram2Addr   (Ram2Addr),
        .Ram2Data   (Ram2Data),
        .Ram2OE     (Ram2OE),
        .Ram2WE     (Ram2WE),
        .Ram2EN     (Ram2EN),
        .data_ready (1'b0),
        .tbre       (1'b0),
        .tsre       (1'b0),
        .wrn        (wrn),
        .rdn        (rdn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives on read, captures while WE is low.
    assign Ram1Data = (!bus.Ram1EN && !bus.Ram1OE) ? sram[bus.Ram1Addr[15:0]]
                    : (probe_en ? probe_val : 16'hzzzz);

    always @(negedge clk) begin
        #2;
        if (!bus.Ram1EN && !bus.Ram1WE) sram[bus.Ram1Addr[15:0]] = Ram1Data;
    end

    task automatic chk_w(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_undriven(input string tag);
        probe_en  = 1'b1;
        probe_val = 16'hA5C3;
        #1;
        chk_w({tag, "_z1"}, {2'b00, Ram1Data}, 18'h0A5C3);
        probe_val = 16'h5A3C;
        #1;
        chk_w({tag, "_z2"}, {2'b00, Ram1Data}, 18'h05A3C);
        probe_en = 1'b0;
    endtask

    task automatic m_write(input logic [2:0] r, input logic [15:0] v);
        m_regs[r] = v;
        m_light   = v;
    endtask

    // ISA-level execution of one instruction; returns its memory activity and the light value after it.
    task automatic model_exec(input logic [15:0] ins, output hist_t h);
        logic [2:0]  rx, ry, rz;
        logic [15:0] a, b, addr;
        int          sh;
        rx = ins[10:8]; ry = ins[7:5]; rz = ins[4:2];
        a  = m_regs[rx]; b = m_regs[ry];
        sh = (ins[4:2] == 3'd0) ? 8 : int'(ins[4:2]);
        addr = a + {{11{ins[4]}}, ins[4:0]};
        h.kind = 0; h.addr = 16'h0; h.data = 16'h0;
        case (ins[15:11])
            5'b01101: m_write(rx, {8'h00, ins[7:0]});
            5'b01001: m_write(rx, a + {{8{ins[7]}}, ins[7:0]});
            5'b11100: begin
                if (ins[1:0] == 2'b01) m_write(rz, a + b);
                else if (ins[1:0] == 2'b11) m_write(rz, a - b);
            end
            5'b11101: begin
                if (ins[4:0] == 5'b01100) m_write(rx, a & b);
                else if (ins[4:0] == 5'b01101) m_write(rx, a | b);
            end
            5'b00110: begin
                if (ins[1:0] == 2'b00) m_write(rx, b << sh);
                else if (ins[1:0] == 2'b11) m_write(rx, $signed(b) >>> sh);
            end
            5'b10011: begin
                h.kind = 1; h.addr = addr;
                m_write(ry, m_mem.exists(addr) ? m_mem[addr] : 16'h0000);
            end
            5'b11011: begin
                h.kind = 2; h.addr = addr; h.data = b;
                m_mem[addr] = b;
            end
            default: ;
        endcase
        h.light = m_light;
    endtask

    task automatic mem_check(input hist_t h, input bit hi);
        string s;
        s = hi ? "hi" : "lo";
        if (h.kind == 2) begin
            chk_b({"sw_en_", s}, bus.Ram1EN, 1'b0);
            chk_b({"sw_oe_", s}, bus.Ram1OE, 1'b1);
            chk_b({"sw_we_", s}, bus.Ram1WE, hi ? 1'b1 : 1'b0);
            chk_w({"sw_addr_", s}, bus.Ram1Addr, {2'b00, h.addr});
            chk_w({"sw_data_", s}, {2'b00, Ram1Data}, {2'b00, h.data});
        end else if (h.kind == 1) begin
            chk_b({"lw_en_", s}, bus.Ram1EN, 1'b0);
            chk_b({"lw_oe_", s}, bus.Ram1OE, 1'b0);
            chk_b({"lw_we_", s}, bus.Ram1WE, 1'b1);
            chk_w({"lw_addr_", s}, bus.Ram1Addr, {2'b00, h.addr});
        end else begin
            chk_b({"idle_en_", s}, bus.Ram1EN, 1'b1);
            chk_b({"idle_oe_", s}, bus.Ram1OE, 1'b1);
            chk_b({"idle_we_", s}, bus.Ram1WE, 1'b1);
            if (hi) chk_undriven("idle_data");
        end
    endtask

    // One instruction per cycle: presented in the low half, latched on the rising edge.
    task automatic issue(input logic [15:0] instr);
        hist_t h;
        int    n;
        bus.l = instr;
        model_exec(instr, h);
        hist.push_back(h);
        n = hist.size();
        @(posedge clk);
        #1;
        chk_w("light", {2'b00, bus.light}, {2'b00, hist[n-3].light});
        mem_check(hist[n-2], 1'b1);
        @(negedge clk);
        #1;
        mem_check(hist[n-2], 1'b0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [2:0] rx, ry, rz;
        logic [7:0] imm;
        logic [15:0] w;
        rx = 3'($urandom); ry = 3'($urandom); rz = 3'($urandom); imm = 8'($urandom);
        case ($urandom_range(0, 11))
            0:  w = {5'b01101, rx, imm};
            1:  w = {5'b01001, rx, imm};
            2:  w = {5'b11100, rx, ry, rz, 2'b01};
            3:  w = {5'b11100, rx, ry, rz, 2'b11};
            4:  w = {5'b11101, rx, ry, 5'b01100};
            5:  w = {5'b11101, rx, ry, 5'b01101};
            6:  w = {5'b00110, rx, ry, imm[2:0], 2'b00};
            7:  w = {5'b00110, rx, ry, imm[2:0], 2'b11};
            8:  w = {5'b10011, rx, ry, imm[4:0]};
            9:  w = {5'b11011, rx, ry, imm[4:0]};
            10: w = {5'b01101, rx, imm};
            default: w = 16'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        hist_t idle;
        rst = 1'b1;
        bus.l = NOP;
        probe_en = 1'b0;
        probe_val = 16'h0000;
        for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
        sram[16'h00BF] = 16'h00BF;
        m_mem[16'h00BF] = 16'h00BF;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_light = 16'h0000;
        idle.kind = 0; idle.addr = 16'h0; idle.data = 16'h0; idle.light = 16'h0;
        hist.push_back(idle);
        hist.push_back(idle);

        // Reset state
        @(posedge clk);
        #1;
        chk_w("rst_light", {2'b00, bus.light}, 18'h0);
        chk_b("rst_en", bus.Ram1EN, 1'b1);
        chk_b("rst_oe", bus.Ram1OE, 1'b1);
        chk_w("rst_addr", bus.Ram1Addr, 18'h0);
        chk_b("rst_wrn", wrn, 1'b1);
        chk_b("rst_rdn", rdn, 1'b1);
        chk_b("rst_ram2en", Ram2EN, 1'b1);
        chk_undriven("rst_data");
        @(negedge clk);
        #1;
        chk_b("rst_we", bus.Ram1WE, 1'b1);
        rst = 1'b0;

        // Directed program
        issue(16'h6800);                     // LI r0,0
        issue(16'h6BBF);                     // LI r3,0xBF
        issue(NOP);
        issue(NOP);
        chk_w("plan_li_r3", {2'b00, bus.light}, 18'h000BF);
        issue(16'hD860);                     // SW r0,r3,0
        issue(NOP);
        issue(16'h9BE0);                     // LW r3,r7,0
        issue(NOP);
        issue(NOP);
        chk_w("plan_lw_r7", {2'b00, bus.light}, 18'h000BF);
        issue(16'h69FF);                     // LI r1,0xFF
        issue(NOP);
        issue(16'h4901);                     // ADDIU r1,1
        issue(NOP);
        issue(NOP);
        chk_w("plan_addiu", {2'b00, bus.light}, 18'h00100);
        issue(16'h3220);                     // SLL r2,r1,8
        issue(NOP);
        issue(NOP);
        chk_w("plan_sll8", {2'b00, bus.light}, 18'h00000);
        issue(16'h6C80);                     // LI r4,0x80
        issue(NOP);
        issue(16'h3587);                     // SRA r5,r4,1
        issue(NOP);
        issue(NOP);
        chk_w("plan_sra", {2'b00, bus.light}, 18'h00040);
        issue(16'h4C80);                     // ADDIU r4,-128
        issue(NOP);
        issue(NOP);
        chk_w("plan_addiu_neg", {2'b00, bus.light}, 18'h00000);
        issue(16'hE4BB);                     // SUBU r4,r5 -> r6
        issue(NOP);
        issue(NOP);
        chk_w("plan_subu", {2'b00, bus.light}, 18'h0FFC0);
        issue(16'hF800);                     // undefined
        issue(NOP);
        issue(NOP);
        chk_w("plan_undef", {2'b00, bus.light}, 18'h0FFC0);

        // Random stream, each instruction followed by a NOP to respect the hazard window
        for (int k = 0; k < 300; k++) begin
            issue(rand_instr());
            issue(NOP);
        end

        // Reset during a store's write strobe aborts it immediately
        issue(16'hD860);
        bus.l = NOP;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk_b("abort_we_pre", bus.Ram1WE, 1'b0);
        rst = 1'b1;
        #1;
        chk_b("abort_we", bus.Ram1WE, 1'b1);
        chk_b("abort_en", bus.Ram1EN, 1'b1);
        chk_w("abort_light", {2'b00, bus.light}, 18'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zzcpu_core.md
Name: zzcpu_core

Overview:
- 16-bit THCO-MIPS-subset CPU core with a 3-stage pipeline: IF/ID, EX, MEM/WB.
- Each clock it takes its instruction directly from the 16-bit switch input `l`; there is no PC and no instruction fetch from memory.
- Data memory is external SRAM Ram1.
- Ram2 and the UART pins are parked inactive.
- `light` shows the most recent register write-back value.

Parameters:
- none (register file fixed at 8×16, datapath fixed at 16 bits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- l  in  16  instruction word, sampled on each rising edge
- light  out  16  last write-back data
- Ram1Addr  out  18  data memory address, {2'b00, addr16}
- Ram1Data  inout  16  data memory bus
- Ram1OE  out  1  output enable, active low
- Ram1WE  out  1  write enable, active low
- Ram1EN  out  1  chip enable, active low
- Ram2Addr  out  18  unused, held 0
- Ram2Data  inout  16  unused, held Z
- Ram2OE, Ram2WE, Ram2EN  out  1 each  unused, held 1
- data_ready, tbre, tsre  in  1 each  UART status, ignored
- wrn, rdn  out  1 each  UART strobes, held 1

Behaviour:
- Reset (async, rst=1):
  - IR = NOP (16'h0800); EX/MEM register = bubble.
  - All 8 registers = 0; light = 0.
  - Ram1EN/OE/WE = 1; Ram1Data = Z; Ram1Addr = 0.
- Stage IF/ID:
  - Edge k: IR <= l.
  - During cycle k: decode IR and read the register file combinationally.
- Stage EX:
  - Edge k+1: the EX/MEM register captures op class, destination register, ALU result / memory address, and store data.
- Stage MEM/WB:
  - During cycle k+1: memory access.
  - Edge k+2: register-file write and light update.
- Register read timing:
  - An instruction latched at edge k+2 already reads the value written at k+2 (write-before-read).
  - There is no forwarding and no interlock. Software inserts NOPs so that a consumer is latched no earlier than the producer's write edge.
- Instruction set (field layout [15:11] op, rx=[10:8], ry=[7:5], rz=[4:2]):
  - NOP  00001 00000000000 → no effect.
  - LI  01101 rx imm8 → rx = zext(imm8).
  - ADDIU  01001 rx imm8 → rx = rx + sext(imm8).
  - ADDU  11100 rx ry rz 01 → rz = rx + ry.
  - SUBU  11100 rx ry rz 11 → rz = rx - ry.
  - AND  11101 rx ry 01100 → rx = rx & ry.
  - OR  11101 rx ry 01101 → rx = rx | ry.
  - SLL  00110 rx ry imm3 00 → rx = ry << imm3; imm3 = 0 means a shift of 8.
  - SRA  00110 rx ry imm3 11 → arithmetic right shift, same shift-amount rule.
  - LW  10011 rx ry imm5 → ry = mem[rx + sext(imm5)].
  - SW  11011 rx ry imm5 → mem[rx + sext(imm5)] = ry.
- Any other encoding behaves as NOP.
- All arithmetic is modulo 2^16.
- Memory cycle, SW:
  - Ram1EN = 0, Ram1OE = 1, Ram1Addr = address, Ram1Data driven with store data for the whole cycle.
  - Ram1WE = 0 only while clk is low (second half of the cycle), so the address and data are stable at both WE edges.
- Memory cycle, LW:
  - Ram1EN = 0, Ram1OE = 0, Ram1WE = 1, Ram1Data = Z.
  - Data is sampled into the destination register at the closing edge.
- Non-memory cycle: Ram1EN/OE/WE = 1, Ram1Data = Z.
- light: on every register write, light <= the written value. Otherwise it holds.
- Reset asserted mid-operation: in-flight instructions are discarded and any Ram1 write is aborted immediately (WE = 1 asynchronously).

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP, OP_LI, OP_ADDIU, OP_RRR, OP_LOGIC, OP_SHIFT, OP_LW, OP_SW)
  - funct constants
  - an ALU-op enum
  - the NOP word 16'h0800
- One sub-module: zzcpu_regfile, 8×16 with 2 async read ports and 1 sync write port, async reset to 0, write-before-read bypass.

Test Plan:
- rst pulse → light = 0, Ram1EN/OE/WE = 1, Ram1Data = Z, wrn = rdn = 1, Ram2EN = 1.
- LI r0,0x00; LI r3,0xBF; 2×NOP → light = 0x00BF after r3's write edge.
- Then SW r0,r3,0: during its MEM cycle Ram1Addr = 0, Ram1Data = 0x00BF, Ram1EN = 0, Ram1WE = 0 in the clk-low half only.
- Then NOP; LW r3,r7,0 (16'h9BE0); 2×NOP:
  - MEM cycle: Ram1OE = 0, Ram1Addr = 0x000BF.
  - Bench models Ram1 returning the stored value; light = 0x00BF; r7 = 0x00BF.
- LI r1,0xFF; NOP; ADDIU r1,0x01 → light = 0x0100. Then SLL r2,r1,0 → light = 0x0000.
- LI r4,0x80; NOP; SRA r5,r4,imm 1 → 0x0040. ADDIU r4,0x80 (−128) → 0x0000. SUBU r4,r5→r6 → light = 0xFFC0. Undefined opcode 16'hF800 → no state change.
